// File: rtl/mips_pkg.sv
// Shared MIPS constants and encode helpers, common to the control decoder and this encoder.
package mips_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned KIND_W  = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OP_W-1:0] OP_LW    = 6'd35;
    localparam logic [OP_W-1:0] OP_SW    = 6'd43;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;

    localparam logic [FUNCT_W-1:0] F_ADD = 6'd32;
    localparam logic [FUNCT_W-1:0] F_SUB = 6'd34;
    localparam logic [FUNCT_W-1:0] F_AND = 6'd36;
    localparam logic [FUNCT_W-1:0] F_OR  = 6'd37;
    localparam logic [FUNCT_W-1:0] F_SLT = 6'd42;

    typedef enum logic [KIND_W-1:0] {
        KIND_RTYPE = 2'd0,
        KIND_LW    = 2'd1,
        KIND_SW    = 2'd2,
        KIND_BEQ   = 2'd3
    } kind_e;

    typedef struct packed {
        kind_e              kind;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
        logic [FUNCT_W-1:0] funct;
        logic [IMM_W-1:0]   imm;
    } instr_req_t;

    // Only the ALU operations the single-cycle datapath implements are legal.
    function automatic logic funct_legal(input logic [FUNCT_W-1:0] f);
        return (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_OR) || (f == F_SLT);
    endfunction

    // Build the 32-bit instruction word; fields unused by a kind are ignored.
    function automatic logic [WORD_W-1:0] encode(input instr_req_t r);
        logic [WORD_W-1:0] w;
        w = '0;
        case (r.kind)
            KIND_RTYPE: w = {OP_RTYPE, r.rs, r.rt, r.rd, 5'd0, r.funct};
            KIND_LW:    w = {OP_LW,    r.rs, r.rt, r.imm};
            KIND_SW:    w = {OP_SW,    r.rs, r.rt, r.imm};
            KIND_BEQ:   w = {OP_BEQ,   r.rs, r.rt, r.imm};
            default:    w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Request side (sequencer) and IM write side of the instruction encoder.
interface mips_instr_encoder_if
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic [KIND_W-1:0]    req_kind;
    logic [REG_W-1:0]     req_rs;
    logic [REG_W-1:0]     req_rt;
    logic [REG_W-1:0]     req_rd;
    logic [FUNCT_W-1:0]   req_funct;
    logic [IMM_W-1:0]     req_imm;
    logic                 im_stall;
    logic                 im_we;
    logic [ADDR_W-1:0]    im_addr;
    logic [WORD_W-1:0]    im_wdata;
    logic [ADDR_W:0]      words_written;
    logic                 err_funct;
    logic                 mem_full;

    modport slave (
        input  req_valid, req_kind, req_rs, req_rt, req_rd, req_funct, req_imm, im_stall,
        output req_ready, im_we, im_addr, im_wdata, words_written, err_funct, mem_full
    );

    modport master (
        output req_valid, req_kind, req_rs, req_rt, req_rd, req_funct, req_imm, im_stall,
        input  req_ready, im_we, im_addr, im_wdata, words_written, err_funct, mem_full
    );
endinterface

// File: rtl/mips_instr_encoder_fifo.sv
// Synchronous FIFO with pointers and occupancy count; head word is visible combinationally.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/mips_instr_encoder.sv
// Encodes instruction requests into MIPS words, queues them and writes them to IM in order.
module mips_instr_encoder
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 restart,
    mips_instr_encoder_if.slave  bus
);
    localparam int unsigned       CNT_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    instr_req_t         w_req;
    logic [WORD_W-1:0]  w_word;
    logic [WORD_W-1:0]  w_head;
    logic               w_clear;
    logic               w_legal;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_fifo_full;
    logic               w_fifo_empty;

    logic               r_im_we;
    logic [ADDR_W-1:0]  r_im_addr;
    logic [WORD_W-1:0]  r_im_wdata;
    logic [ADDR_W-1:0]  r_next_addr;
    logic [CNT_W-1:0]   r_words_written;
    logic               r_err_funct;
    logic               r_mem_full;

    assign w_clear = rst || restart;
    assign w_req   = '{kind:  kind_e'(bus.req_kind),
                       rs:    bus.req_rs,
                       rt:    bus.req_rt,
                       rd:    bus.req_rd,
                       funct: bus.req_funct,
                       imm:   bus.req_imm};
    assign w_word  = encode(w_req);
    assign w_legal = (w_req.kind != KIND_RTYPE) || funct_legal(w_req.funct);

    // Ready depends on occupancy only: a same-cycle pop never frees a slot early.
    assign bus.req_ready = !w_fifo_full && !w_clear;
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_push        = w_accept && w_legal;
    assign w_pop         = !w_fifo_empty && !bus.im_stall && !r_mem_full;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (w_clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_word),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // IM write port: one strobe per popped word; address/data hold while idle.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_im_we         <= 1'b0;
            r_im_addr       <= ADDR_BASE;
            r_im_wdata      <= '0;
            r_next_addr     <= ADDR_BASE;
            r_words_written <= '0;
            r_mem_full      <= 1'b0;
        end else begin
            r_im_we <= w_pop;
            if (w_pop) begin
                r_im_addr       <= r_next_addr;
                r_im_wdata      <= w_head;
                r_next_addr     <= r_next_addr + ADDR_W'(1);
                r_words_written <= r_words_written + CNT_W'(1);
                if (r_next_addr == ADDR_LAST) begin
                    r_mem_full <= 1'b1;
                end
            end
        end
    end

    // Sticky record of a dropped RTYPE request with an unsupported funct.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_err_funct <= 1'b0;
        end else if (w_accept && !w_legal) begin
            r_err_funct <= 1'b1;
        end
    end

    assign bus.im_we         = r_im_we;
    assign bus.im_addr       = r_im_addr;
    assign bus.im_wdata      = r_im_wdata;
    assign bus.words_written = r_words_written;
    assign bus.err_funct     = r_err_funct;
    assign bus.mem_full      = r_mem_full;
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: reference model on instance A, directed corners on A and B.
module tb_mips_instr_encoder;
    import mips_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, restart_a, rst_b, restart_b;

    mips_instr_encoder_if #(.ADDR_W(8)) bus_a ();
    mips_instr_encoder_if #(.ADDR_W(2)) bus_b ();

    mips_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(8), .BASE_ADDR(0)) u_dut_a (
        .clk(clk), .rst(rst_a), .restart(restart_a), .bus(bus_a));
    mips_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(2), .BASE_ADDR(0)) u_dut_b (
        .clk(clk), .rst(rst_b), .restart(restart_b), .bus(bus_b));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction word from field values by place-value arithmetic.
    function automatic logic [31:0] ref_word(input int kind, input int rs, input int rt,
                                             input int rd, input int funct, input int imm);
        longint unsigned v;
        longint unsigned op;
        case (kind)
            0: op = 0;
            1: op = 35;
            2: op = 43;
            default: op = 4;
        endcase
        if (kind == 0)
            v = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + longint'(funct);
        else
            v = op * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
        return v[31:0];
    endfunction

    function automatic bit ref_legal(input int kind, input int funct);
        return (kind != 0) || (funct inside {32, 34, 36, 37, 42});
    endfunction

    // Reference model of instance A: a queue of pending words plus the IM-side view.
    logic [31:0] m_q[$];
    bit          m_we, m_err, m_full, m_live, m_take, m_pop;
    int          m_addr, m_ww, m_next;
    logic [31:0] m_wdata;

    always @(posedge clk) begin
        if (rst_a || restart_a) begin
            m_q.delete();
            m_we = 0; m_addr = 0; m_wdata = 0; m_ww = 0; m_err = 0; m_full = 0; m_next = 0;
        end else begin
            m_take = (m_q.size() < DEPTH);
            m_pop  = (m_q.size() > 0) && !bus_a.im_stall && !m_full;
            if (m_pop) begin
                m_we    = 1;
                m_wdata = m_q.pop_front();
                m_addr  = m_next;
                m_ww    = m_ww + 1;
                if (m_next == 255) m_full = 1;
                m_next  = m_next + 1;
            end else begin
                m_we = 0;
            end
            if (bus_a.req_valid && m_take) begin
                if (ref_legal(int'(bus_a.req_kind), int'(bus_a.req_funct)))
                    m_q.push_back(ref_word(int'(bus_a.req_kind), int'(bus_a.req_rs),
                                           int'(bus_a.req_rt), int'(bus_a.req_rd),
                                           int'(bus_a.req_funct), int'(bus_a.req_imm)));
                else
                    m_err = 1;
            end
        end
        m_live = 1;
    end

    // Every cycle, compare all of instance A's outputs to the model.
    always @(negedge clk) begin
        if (m_live) begin
            check("a_im_we",    64'(bus_a.im_we),         64'(m_we));
            check("a_im_addr",  64'(bus_a.im_addr),       64'(m_addr));
            check("a_im_wdata", 64'(bus_a.im_wdata),      64'(m_wdata));
            check("a_words",    64'(bus_a.words_written), 64'(m_ww));
            check("a_err",      64'(bus_a.err_funct),     64'(m_err));
            check("a_full",     64'(bus_a.mem_full),      64'(m_full));
            check("a_ready",    64'(bus_a.req_ready),
                  64'(!rst_a && !restart_a && (m_q.size() < DEPTH)));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_a(input bit v, input int kind, input int rs, input int rt,
                           input int rd, input int funct, input int imm);
        bus_a.req_valid = v;
        bus_a.req_kind  = 2'(kind);
        bus_a.req_rs    = 5'(rs);
        bus_a.req_rt    = 5'(rt);
        bus_a.req_rd    = 5'(rd);
        bus_a.req_funct = 6'(funct);
        bus_a.req_imm   = 16'(imm);
    endtask

    task automatic drive_b(input bit v, input int rs, input int rt, input int imm);
        bus_b.req_valid = v;
        bus_b.req_kind  = 2'd3;
        bus_b.req_rs    = 5'(rs);
        bus_b.req_rt    = 5'(rt);
        bus_b.req_rd    = 5'd0;
        bus_b.req_funct = 6'd0;
        bus_b.req_imm   = 16'(imm);
    endtask

    task automatic restart_pulse_a();
        restart_a = 1;
        step();
        restart_a = 0;
    endtask

    typedef struct {
        int          kind, rs, rt, rd, funct, imm;
        logic [31:0] exp_word;
        bit          legal;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] exp3[5];

    initial begin
        rst_a = 1; restart_a = 0; rst_b = 1; restart_b = 0;
        drive_a(0, 0, 0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
        bus_a.im_stall = 0;
        bus_b.im_stall = 0;

        // Reset state while rst is still high.
        step(2);
        check("rst_we",    64'(bus_a.im_we), 64'd0);
        check("rst_addr",  64'(bus_a.im_addr), 64'd0);
        check("rst_wdata", 64'(bus_a.im_wdata), 64'd0);
        check("rst_words", 64'(bus_a.words_written), 64'd0);
        check("rst_ready", 64'(bus_a.req_ready), 64'd0);
        rst_a = 0; rst_b = 0;
        step();
        check("rst_ready_after", 64'(bus_a.req_ready), 64'd1);

        // LW write appears two clocks after acceptance.
        drive_a(1, 1, 1, 2, 0, 0, 4);
        step();
        drive_a(0, 0, 0, 0, 0, 0, 0);
        check("t1_we_early", 64'(bus_a.im_we), 64'd0);
        step();
        check("t1_we",    64'(bus_a.im_we), 64'd1);
        check("t1_addr",  64'(bus_a.im_addr), 64'd0);
        check("t1_wdata", 64'(bus_a.im_wdata), 64'h8C220004);

        // Back-to-back RTYPE then SW land on consecutive cycles and addresses.
        restart_pulse_a();
        drive_a(1, 0, 1, 2, 3, 32, 0);
        step();
        drive_a(1, 2, 0, 3, 0, 0, 8);
        step();
        drive_a(0, 0, 0, 0, 0, 0, 0);
        check("t2_w0_we",    64'(bus_a.im_we), 64'd1);
        check("t2_w0_addr",  64'(bus_a.im_addr), 64'd0);
        check("t2_w0_wdata", 64'(bus_a.im_wdata), 64'h00221820);
        step();
        check("t2_w1_we",    64'(bus_a.im_we), 64'd1);
        check("t2_w1_addr",  64'(bus_a.im_addr), 64'd1);
        check("t2_w1_wdata", 64'(bus_a.im_wdata), 64'hAC030008);
        check("t2_words",    64'(bus_a.words_written), 64'd2);

        // Stall fills the FIFO; release drains in order and admits the fifth request.
        restart_pulse_a();
        bus_a.im_stall = 1;
        for (int i = 0; i < 4; i++) begin
            exp3[i] = ref_word(1, i, i + 1, 0, 0, 256 + i);
            drive_a(1, 1, i, i + 1, 0, 0, 256 + i);
            step();
        end
        check("t3_ready_full", 64'(bus_a.req_ready), 64'd0);
        check("t3_we_stalled", 64'(bus_a.im_we), 64'd0);
        exp3[4] = ref_word(1, 4, 5, 0, 0, 260);
        drive_a(1, 1, 4, 5, 0, 0, 260);
        bus_a.im_stall = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 1) drive_a(0, 0, 0, 0, 0, 0, 0);
            check("t3_we",    64'(bus_a.im_we), 64'd1);
            check("t3_addr",  64'(bus_a.im_addr), 64'(k));
            check("t3_wdata", 64'(bus_a.im_wdata), 64'(exp3[k]));
        end
        step();
        check("t3_we_done", 64'(bus_a.im_we), 64'd0);

        // Illegal funct: accepted, dropped, sticky error until restart.
        restart_pulse_a();
        drive_a(1, 0, 1, 2, 3, 7, 0);
        step();
        drive_a(0, 0, 0, 0, 0, 0, 0);
        check("t4_err", 64'(bus_a.err_funct), 64'd1);
        step();
        check("t4_no_we", 64'(bus_a.im_we), 64'd0);
        step(3);
        check("t4_err_sticky", 64'(bus_a.err_funct), 64'd1);
        check("t4_words", 64'(bus_a.words_written), 64'd0);
        restart_pulse_a();
        check("t4_err_clr", 64'(bus_a.err_funct), 64'd0);

        // Encoding table, including ignored fields and funct legality neighbours.
        vecs[0] = '{1,  1,  2, 0,  0, 4,      32'h8C220004, 1'b1};
        vecs[1] = '{0,  1,  2, 3, 32, 0,      32'h00221820, 1'b1};
        vecs[2] = '{2,  0,  3, 0,  0, 8,      32'hAC030008, 1'b1};
        vecs[3] = '{3,  5,  6, 0,  0, 65535,  32'h10A6FFFF, 1'b1};
        vecs[4] = '{0, 31, 31, 31, 42, 0,     32'h03FFF82A, 1'b1};
        vecs[5] = '{0,  2,  3, 4, 34, 0,      32'h00432022, 1'b1};
        vecs[6] = '{0,  1,  1, 2, 36, 0,      32'h00211024, 1'b1};
        vecs[7] = '{0,  0,  0, 1, 37, 0,      32'h00000825, 1'b1};
        vecs[8] = '{1, 31,  0, 5,  7, 32768,  32'h8FE08000, 1'b1};
        vecs[9] = '{0,  1,  2, 3, 33, 0,      32'h0,        1'b0};
        for (int v = 0; v < 10; v++) begin
            drive_a(1, vecs[v].kind, vecs[v].rs, vecs[v].rt, vecs[v].rd, vecs[v].funct, vecs[v].imm);
            step();
            drive_a(0, 0, 0, 0, 0, 0, 0);
            step();
            check("tbl_we", 64'(bus_a.im_we), 64'(vecs[v].legal));
            if (vecs[v].legal)
                check("tbl_wdata", 64'(bus_a.im_wdata), 64'(vecs[v].exp_word));
            else
                check("tbl_err", 64'(bus_a.err_funct), 64'd1);
        end

        // Reset in the middle of a drain discards queued words.
        restart_pulse_a();
        bus_a.im_stall = 1;
        for (int i = 0; i < 4; i++) begin
            drive_a(1, 3, i, i, 0, 0, i);
            step();
        end
        drive_a(0, 0, 0, 0, 0, 0, 0);
        bus_a.im_stall = 0;
        step();
        check("t6_first_we", 64'(bus_a.im_we), 64'd1);
        rst_a = 1;
        step();
        check("t6_we",    64'(bus_a.im_we), 64'd0);
        check("t6_addr",  64'(bus_a.im_addr), 64'd0);
        check("t6_words", 64'(bus_a.words_written), 64'd0);
        rst_a = 0;
        step(2);
        check("t6_empty_we", 64'(bus_a.im_we), 64'd0);
        check("t6_ready",    64'(bus_a.req_ready), 64'd1);

        // Small IM (ADDR_W=2): writes stop after address 3, leftovers stay queued.
        for (int j = 0; j < 6; j++) begin
            check("t5_ready", 64'(bus_b.req_ready), 64'd1);
            drive_b(1, 1, 2, j);
            step();
            if (j >= 1 && j <= 4) begin
                check("t5_we",    64'(bus_b.im_we), 64'd1);
                check("t5_addr",  64'(bus_b.im_addr), 64'(j - 1));
                check("t5_wdata", 64'(bus_b.im_wdata), 64'(ref_word(3, 1, 2, 0, 0, j - 1)));
            end else if (j == 5) begin
                check("t5_we_stop", 64'(bus_b.im_we), 64'd0);
            end
        end
        drive_b(0, 0, 0, 0);
        step(2);
        check("t5_full",  64'(bus_b.mem_full), 64'd1);
        check("t5_words", 64'(bus_b.words_written), 64'd4);
        check("t5_we_idle", 64'(bus_b.im_we), 64'd0);
        check("t5_room", 64'(bus_b.req_ready), 64'd1);
        drive_b(1, 7, 7, 99);
        step(2);
        drive_b(0, 0, 0, 0);
        check("t5_ready_full", 64'(bus_b.req_ready), 64'd0);
        check("t5_still_full", 64'(bus_b.mem_full), 64'd1);
        restart_b = 1;
        step();
        restart_b = 0;
        step();
        check("t5_full_clr", 64'(bus_b.mem_full), 64'd0);
        check("t5_addr_clr", 64'(bus_b.im_addr), 64'd0);
        check("t5_ready_clr", 64'(bus_b.req_ready), 64'd1);

        // Random traffic on instance A against the model; late phase runs into mem_full.
        restart_pulse_a();
        for (int cyc = 0; cyc < 1400; cyc++) begin
            int kind, funct;
            kind = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) funct = int'($urandom_range(0, 63));
            else begin
                case ($urandom_range(0, 4))
                    0: funct = 32; 1: funct = 34; 2: funct = 36; 3: funct = 37; default: funct = 42;
                endcase
            end
            drive_a($urandom_range(0, 9) < 7, kind, int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), funct,
                    int'($urandom_range(0, 65535)));
            bus_a.im_stall = ($urandom_range(0, 3) == 0);
            restart_a = (cyc < 500) && ($urandom_range(0, 99) == 0);
            step();
        end
        drive_a(0, 0, 0, 0, 0, 0, 0);
        bus_a.im_stall = 0;
        restart_a = 0;
        step(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
